// File: rtl/dsp_casc_pkg.sv
// ----------------------------------------------------------------------------
// dsp_casc_pkg
// Shared types and constants for the cascaded DSP-slice product sequencer.
//   state_t        : sequencer FSM states
//   OPM_*          : DSP OPMODE values driven by the sequencer
//   issue_opcode() : opcode selected for one operand issue
// ----------------------------------------------------------------------------
package dsp_casc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [6:0] OPM_ZERO     = 7'h00;
    localparam logic [6:0] OPM_M_C      = 7'h35;
    localparam logic [6:0] OPM_M_PCIN17 = 7'h55;

    // The first word of each row adds the C input; later words accumulate
    // the cascaded P shifted down by one 17-bit word.
    function automatic logic [6:0] issue_opcode(input logic first_word);
        return first_word ? OPM_M_C : OPM_M_PCIN17;
    endfunction

endpackage

// File: rtl/dsp_ctrl_delay.sv
// ----------------------------------------------------------------------------
// dsp_ctrl_delay
// Parameterised-width, parameterised-depth shift register used to align
// control signals with the DSP slice pipeline. DEPTH=0 is a plain wire.
//   clk_sys : clock
//   rst_b   : asynchronous active-low clear of all stages
//   flush   : synchronous clear of all stages
//   d       : input word
//   q       : d delayed by DEPTH cycles
// ----------------------------------------------------------------------------
module dsp_ctrl_delay #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk_sys,
    input  logic         rst_b,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctl;
            assign unused_ctl = ^{clk_sys, rst_b, flush};
            assign q = d;
        end else begin : g_shift
            logic [W-1:0] stage [DEPTH];

            always_ff @(posedge clk_sys or negedge rst_b) begin
                if (!rst_b) begin
                    for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
                end else if (flush) begin
                    for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
                end else begin
                    stage[0] <= d;
                    for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/dsp_casc_seq_ctrl.sv
// ----------------------------------------------------------------------------
// dsp_casc_seq_ctrl
// Sequences one S-by-S word product through a single cascaded DSP slice:
// issues every (i, j) operand pair, then drives OPMODE, C enable and P-valid
// aligned to the slice's register depths.
//
// Optional feature macro: DSP_SEQ_ABORT_EN adds abort_i, which cancels a
// sequence in RUN or DRAIN and flushes the delay lines without a done pulse.
//
// Ports:
//   clock_i    : clock
//   reset_n_i  : asynchronous active-low reset
//   start_i    : request one sequence (accepted in IDLE only)
//   abort_i    : cancel sequence (only with DSP_SEQ_ABORT_EN)
//   busy_o     : sequence in progress, through done_o
//   done_o     : last result word valid at P (one-cycle pulse)
//   i_idx_o    : B word index of the current issue (0 when not issuing)
//   j_idx_o    : A word index of the current issue (0 when not issuing)
//   issue_o    : operands for i_idx_o/j_idx_o are presented this cycle
//   OPMODE_o   : DSP OPMODE, aligned for OPMODEREG=1
//   CREG_en_o  : C register clock enable
//   p_valid_o  : P holds a valid result word
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | issuing S*S operand pairs, one per cycle
// DRAIN | letting the last issue reach P (DSP_REG_LEVEL cycles)
// DONE  | one-cycle done_o pulse, then back to IDLE
// ----------------------------------------------------------------------------
module dsp_casc_seq_ctrl
    import dsp_casc_pkg::*;
#(
    parameter int  S             = 4,
    parameter int  ABREG         = 1,
    parameter int  MREG          = 1,
    parameter int  CREG          = 1,
    localparam int DSP_REG_LEVEL = 1 + ABREG + MREG,
    localparam int IW            = $clog2(S)
) (
    input  logic          clock_i,
    input  logic          reset_n_i,
    input  logic          start_i,
`ifdef DSP_SEQ_ABORT_EN
    input  logic          abort_i,
`endif
    output logic          busy_o,
    output logic          done_o,
    output logic [IW-1:0] i_idx_o,
    output logic [IW-1:0] j_idx_o,
    output logic          issue_o,
    output logic [6:0]    OPMODE_o,
    output logic          CREG_en_o,
    output logic          p_valid_o
);

    localparam int OPM_DLY = ABREG + MREG;
    localparam int CEN_DLY = ABREG + MREG - CREG;
    localparam int DW      = $clog2(DSP_REG_LEVEL + 1);

    localparam logic [IW-1:0] LAST_IDX   = IW'(S - 1);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DSP_REG_LEVEL - 1);

    state_t        state;
    logic [DW-1:0] drain_cnt;
    logic          abort_hit;
    logic [6:0]    opm_issue;
    logic          cen_issue;

`ifdef DSP_SEQ_ABORT_EN
    assign abort_hit = abort_i && ((state == RUN) || (state == DRAIN));
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state     <= IDLE;
            drain_cnt <= '0;
            i_idx_o   <= '0;
            j_idx_o   <= '0;
            issue_o   <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else if (abort_hit) begin
            state     <= IDLE;
            drain_cnt <= '0;
            i_idx_o   <= '0;
            j_idx_o   <= '0;
            issue_o   <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        state   <= RUN;
                        busy_o  <= 1'b1;
                        issue_o <= 1'b1;
                        i_idx_o <= '0;
                        j_idx_o <= '0;
                    end
                end
                RUN: begin
                    if (j_idx_o == LAST_IDX) begin
                        j_idx_o <= '0;
                        if (i_idx_o == LAST_IDX) begin
                            i_idx_o   <= '0;
                            issue_o   <= 1'b0;
                            state     <= DRAIN;
                            drain_cnt <= DRAIN_INIT;
                        end else begin
                            i_idx_o <= i_idx_o + 1'b1;
                        end
                    end else begin
                        j_idx_o <= j_idx_o + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-issue control derived from the registered issue outputs, then
    // aligned to the slice pipeline by the delay lines.
    assign opm_issue = issue_o ? issue_opcode(j_idx_o == '0) : OPM_ZERO;
    assign cen_issue = issue_o && (j_idx_o == '0);

    dsp_ctrl_delay #(.W(7), .DEPTH(OPM_DLY)) u_opm_dly (
        .clk_sys (clock_i),
        .rst_b   (reset_n_i),
        .flush   (abort_hit),
        .d       (opm_issue),
        .q       (OPMODE_o)
    );

    dsp_ctrl_delay #(.W(1), .DEPTH(CEN_DLY)) u_cen_dly (
        .clk_sys (clock_i),
        .rst_b   (reset_n_i),
        .flush   (abort_hit),
        .d       (cen_issue),
        .q       (CREG_en_o)
    );

    dsp_ctrl_delay #(.W(1), .DEPTH(DSP_REG_LEVEL)) u_pv_dly (
        .clk_sys (clock_i),
        .rst_b   (reset_n_i),
        .flush   (abort_hit),
        .d       (issue_o),
        .q       (p_valid_o)
    );

endmodule

// File: doc/dsp_casc_seq_ctrl.md
DSP_CASC_SEQ_CTRL -- requirements
Module: dsp_casc_seq_ctrl

Interface
REQ-001 Parameter S, default 4, operand length in 17-bit words; legal range 2..64.
REQ-002 Parameter ABREG, default 1, A/B register depth of the sequenced DSP slice.
REQ-003 Parameter MREG, default 1, multiplier register depth of the sequenced DSP slice.
REQ-004 Parameter CREG, default 1, C register depth of the sequenced DSP slice (0 or 1).
REQ-005 Localparam DSP_REG_LEVEL = 1+ABREG+MREG, the issue-to-P latency.
REQ-006 Localparam IW = $clog2(S), the width of the index outputs.
REQ-007 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low. Ports are listed in REQ-008..REQ-018.
REQ-008 clock_i  in  1  sole clock, rising edge.
REQ-009 reset_n_i  in  1  asynchronous active-low reset.
REQ-010 start_i  in  1  one-cycle request to run one S-by-S product sequence.
REQ-011 busy_o  out  1  high from the cycle after start is accepted until done_o inclusive.
REQ-012 done_o  out  1  one-cycle pulse when the last result word is valid at P.
REQ-013 i_idx_o  out  IW  outer (B word) index of the operands being issued this cycle.
REQ-014 j_idx_o  out  IW  inner (A word) index of the operands being issued this cycle.
REQ-015 issue_o  out  1  high when the operands selected by i_idx_o/j_idx_o are presented to A_i/B_i.
REQ-016 OPMODE_o  out  7  DSP OPMODE, aligned for OPMODEREG=1.
REQ-017 CREG_en_o  out  1  C register clock enable.
REQ-018 p_valid_o  out  1  DSP P output holds a valid result word this cycle.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-020 In IDLE, start_i=1 SHALL move the FSM to RUN; start_i in any other state SHALL be ignored.
REQ-021 In RUN, issue_o SHALL be 1 every cycle; j SHALL step 0..S-1, then wrap to 0 while i increments; RUN SHALL last exactly S*S cycles.
REQ-022 After the issue with i=j=S-1, the FSM SHALL enter DRAIN for DSP_REG_LEVEL cycles, then DONE for one cycle, then IDLE.
REQ-023 Per issue, opcode = 0x35 (M+C) when j=0 and 0x55 (M+PCIN>>17) when j>0.
REQ-024 OPMODE_o SHALL present each issue's opcode exactly ABREG+MREG cycles after its issue cycle, and 0x00 in all other cycles.
REQ-025 CREG_en_o SHALL be 1 exactly ABREG+MREG-CREG cycles after every j=0 issue, and 0 otherwise.
REQ-026 p_valid_o SHALL be 1 exactly DSP_REG_LEVEL cycles after each issue cycle.
REQ-027 done_o SHALL coincide with the cycle after the final p_valid_o.
REQ-028 i_idx_o and j_idx_o SHALL read 0 whenever issue_o=0.
REQ-029 Delay lines SHALL flush naturally in DRAIN; no opcode SHALL be emitted after DONE.

Reset
REQ-030 Reset assertion SHALL force IDLE and zero all counters and delay lines immediately, at any point including mid-RUN or mid-DRAIN.
REQ-031 While in reset, all outputs SHALL be 0 (OPMODE_o=0x00).
REQ-032 The first start_i SHALL be accepted at the first rising edge after deassertion.

Configuration
REQ-033 Macro DSP_SEQ_ABORT_EN SHALL control an abort_i input (1 bit) on the module.
- Defined: abort_i=1 in RUN or DRAIN SHALL return the FSM to IDLE next cycle, clear the delay lines (OPMODE_o=0, p_valid_o=0 next cycle), and produce no done_o pulse.
- Undefined: the abort_i port and its logic SHALL be absent.

Structure
REQ-034 Package dsp_casc_pkg SHALL hold the state enum and the opcode constants OPM_ZERO=0x00, OPM_M_C=0x35 and OPM_M_PCIN17=0x55.
REQ-035 One sub-module, dsp_ctrl_delay, SHALL be used: a parameterised-width, parameterised-depth shift register with asynchronous active-low clear, one instance per delay line.

Verification (S=4, ABREG=MREG=CREG=1, start_i sampled at edge 0)
REQ-036 Nominal run -> issue_o high cycles 1..16; OPMODE_o 0x35 at cycles 3,7,11,15 and 0x55 at the other cycles 4..18; p_valid_o high cycles 4..19; done_o at cycle 20; busy_o high cycles 1..20.
REQ-037 Nominal run -> CREG_en_o high exactly at cycles 2,6,10,14.
REQ-038 start_i held high for 30 cycles -> a single sequence runs, then a second starts only after IDLE is re-entered (at cycle 21).
REQ-039 reset_n_i low at cycle 9 -> all outputs 0 during reset; after release with start_i, sequence restarts at i=j=0.
REQ-040 With DSP_SEQ_ABORT_EN, abort_i at cycle 6 -> OPMODE_o=0 and p_valid_o=0 from cycle 7; done_o never pulses; the next start_i is accepted.
REQ-041 Corner S=2, ABREG=2 -> OPMODE_o first nonzero at issue+3; p_valid_o at issue+4; done_o at cycle 9.
